mult8_result_assembler: RTL and testbench

- Consumer end of the 8-lane 8x8 vector multiplier datapath.
- Takes the eight unsigned 16-bit partial products from the multiplier array, together with the per-byte operand sign bits that travel alongside them.
- Shifts and sums the partial products according to SEW, and applies sign correction (two's complement) per element.
- Emits a registered, widened 64-bit result. SEW=32 operations arrive as two consecutive beats and are accumulated internally.

---
 rtl/vmul_pkg.sv | 8 +
 rtl/mult8_beat_sum.sv | 13 +
 rtl/mult8_result_assembler.sv | 77 +++++++
 tb/tb_mult8_result_assembler.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/vmul_pkg.sv
// vmul_pkg: shared types and sizing for the 8-lane vector multiplier datapath
package vmul_pkg;
  localparam int NUM_MULT = 8;
  localparam int PROD_W = 16;
  localparam int RES_W = 64;
  typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW_RSVD} sew_e;
  typedef enum logic {IDLE, ACC} asm_state_e;
endpackage

// File: rtl/mult8_beat_sum.sv
// mult8_beat_sum: weighted sum of eight 8x8 partial products (one 32x16 beat)
module mult8_beat_sum
  import vmul_pkg::*;
(
  input  logic [NUM_MULT-1:0][PROD_W-1:0] p,
  output logic [47:0]                     sum
);
  always_comb begin
    sum = '0;
    for (int j = 0; j < 4; j++)
      sum = sum + (48'(p[j]) << (8 * j)) + (48'(p[j+4]) << (8 * j + 8));
  end
endmodule

// File: rtl/mult8_result_assembler.sv
// mult8_result_assembler: shifts/sums partial products per SEW, sign-corrects and registers the widened result
module mult8_result_assembler
  import vmul_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [1:0]                      sew,
  input  logic [NUM_MULT-1:0][PROD_W-1:0] prod,
  input  logic [3:0]                      sign_a,
  input  logic [3:0]                      sign_b,
  output logic                            out_valid,
  output logic [1:0]                      out_sew,
  output logic [RES_W-1:0]                result,
  output logic                            err
);
  sew_e s;
  asm_state_e state, state_n;
  logic [47:0] acc, s0;
  logic acc_neg, ov_n, err_n, cap;
  logic [NUM_MULT-1:0][PROD_W-1:0] q0;
  logic [31:0] e1;
  logic [RES_W-1:0] res8, res16, tot, res_n;
  assign s = sew_e'(sew);
  // SEW=16 element 0 reuses the beat adder by parking p2/p3 in the <<8 half
  assign q0 = (s == SEW32) ? prod : {32'h0, prod[3], prod[2], 32'h0, prod[1], prod[0]};
  mult8_beat_sum u_sum (.p(q0), .sum(s0));
  assign e1 = 32'(prod[4]) + (32'(prod[5]) << 8) + (32'(prod[6]) << 8) + (32'(prod[7]) << 16);
  assign res16 = {(sign_a[3] ^ sign_b[3]) ? -e1 : e1,
                  (sign_a[1] ^ sign_b[1]) ? -s0[31:0] : s0[31:0]};
  assign tot = 64'(acc) + (64'(s0) << 16);
  always_comb begin
    res8 = '0;
    for (int i = 0; i < 4; i++)
      res8[16*i +: 16] = (sign_a[i] ^ sign_b[i]) ? -prod[i] : prod[i];
  end
  always_comb begin
    state_n = state;
    ov_n = 1'b0;
    err_n = 1'b0;
    cap = 1'b0;
    res_n = res8;
    if (in_valid) begin
      err_n = (state == ACC && s != SEW32) || s == SEW_RSVD;
      ov_n = s == SEW8 || s == SEW16 || (s == SEW32 && state == ACC);
      cap = s == SEW32 && state == IDLE;
      state_n = cap ? ACC : IDLE;
      res_n = (s == SEW32) ? (acc_neg ? -tot : tot) : (s == SEW16) ? res16 : res8;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      acc_neg <= 1'b0;
      out_valid <= 1'b0;
      err <= 1'b0;
      out_sew <= '0;
      result <= '0;
    end else begin
      state <= state_n;
      out_valid <= ov_n;
      err <= err_n;
      if (ov_n) begin
        result <= res_n;
        out_sew <= sew;
      end
      if (cap) begin
        acc <= s0;
        acc_neg <= sign_a[3] ^ sign_b[3];
      end else if (state_n == IDLE) begin
        acc <= '0;
        acc_neg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mult8_result_assembler.sv
// tb_mult8_result_assembler: directed vectors with hand-computed products
module tb_mult8_result_assembler;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_valid, err;
  logic [1:0] sew = 2'b00, out_sew;
  logic [7:0][15:0] prod = '0;
  logic [3:0] sign_a = '0, sign_b = '0;
  logic [63:0] result;
  logic [7:0][15:0] p;
  int n_vec = 0, n_err = 0;

  mult8_result_assembler dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .sew(sew), .prod(prod),
    .sign_a(sign_a), .sign_b(sign_b), .out_valid(out_valid), .out_sew(out_sew),
    .result(result), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [1:0] s, input logic [7:0][15:0] pp, input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    sew = s;
    prod = pp;
    sign_a = a;
    sign_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    prod = '0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ov", 64'(out_valid), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_sew", 64'(out_sew), 64'h0);
    chk("rst_res", result, 64'h0);
    reset = 1'b0;
    // SEW8: lane0 6 negated, lane1 0x4000 with cancelling signs
    p = '0; p[0] = 16'h0006; p[1] = 16'h4000;
    beat(2'b00, p, 4'b0010, 4'b0011);
    chk("s8_ov", 64'(out_valid), 64'h1);
    chk("s8_res", result, 64'h00000000_4000FFFA);
    chk("s8_sew", 64'(out_sew), 64'h0);
    idle();
    chk("s8_pulse", 64'(out_valid), 64'h0);
    chk("s8_hold", result, 64'h00000000_4000FFFA);
    // SEW16 element 1 only: 1<<16 negated
    p = '0; p[7] = 16'h0001;
    beat(2'b01, p, 4'b1000, 4'b0000);
    chk("s16e1_ov", 64'(out_valid), 64'h1);
    chk("s16e1_res", result, 64'hFFFF0000_00000000);
    chk("s16e1_sew", 64'(out_sew), 64'h1);
    // SEW16 element 0: 1 + 2<<8 + 3<<8 + 4<<16 = 0x40501, negated
    p = '0; p[0] = 16'h1; p[1] = 16'h2; p[2] = 16'h3; p[3] = 16'h4;
    beat(2'b01, p, 4'b0010, 4'b0000);
    chk("s16e0_res", result, 64'h00000000_FFFBFAFF);
    // SEW32 with held gap between beats
    p = '0; p[0] = 16'h0002;
    beat(2'b10, p, 4'b1000, 4'b0000);
    chk("s32_b0_ov", 64'(out_valid), 64'h0);
    idle();
    idle();
    chk("s32_hold_ov", 64'(out_valid), 64'h0);
    p = '0;
    beat(2'b10, p, 4'b0000, 4'b0000);
    chk("s32_ov", 64'(out_valid), 64'h1);
    chk("s32_res", result, 64'hFFFFFFFF_FFFFFFFE);
    chk("s32_sew", 64'(out_sew), 64'h2);
    // SEW32 max magnitude 0xFFFFFFFF^2, back-to-back beats
    p = {8{16'hFE01}};
    beat(2'b10, p, 4'b0000, 4'b0000);
    chk("max_b0_ov", 64'(out_valid), 64'h0);
    beat(2'b10, p, 4'b0000, 4'b0000);
    chk("max_res", result, 64'hFFFFFFFE_00000001);
    // abort: SEW8 beat during ACC yields err and its own result
    p = '0; p[0] = 16'h0005;
    beat(2'b10, p, 4'b1000, 4'b0000);
    p = '0; p[0] = 16'h0009;
    beat(2'b00, p, 4'b0000, 4'b0000);
    chk("abort_err", 64'(err), 64'h1);
    chk("abort_ov", 64'(out_valid), 64'h1);
    chk("abort_res", result, 64'h9);
    // back in IDLE: fresh two-beat op, beat1 p0=1 -> 1<<16
    p = '0;
    beat(2'b10, p, 4'b0000, 4'b0000);
    chk("post_abort_b0_ov", 64'(out_valid), 64'h0);
    chk("post_abort_b0_err", 64'(err), 64'h0);
    p[0] = 16'h0001;
    beat(2'b10, p, 4'b0000, 4'b0000);
    chk("post_abort_res", result, 64'h00000000_00010000);
    // reserved SEW during ACC: err only
    p = '0; p[0] = 16'h0004;
    beat(2'b10, p, 4'b0000, 4'b0000);
    beat(2'b11, p, 4'b0000, 4'b0000);
    chk("rsvd_acc_err", 64'(err), 64'h1);
    chk("rsvd_acc_ov", 64'(out_valid), 64'h0);
    // reset mid-ACC
    p = '0; p[0] = 16'h0007;
    beat(2'b10, p, 4'b1000, 4'b0000);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mrst_ov", 64'(out_valid), 64'h0);
    chk("mrst_err", 64'(err), 64'h0);
    chk("mrst_res", result, 64'h0);
    chk("mrst_sew", 64'(out_sew), 64'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    p = '0; p[0] = 16'h0003;
    beat(2'b10, p, 4'b0000, 4'b0000);
    chk("mrst_b0_ov", 64'(out_valid), 64'h0);
    p = '0;
    beat(2'b10, p, 4'b0000, 4'b0000);
    chk("mrst_b1_ov", 64'(out_valid), 64'h1);
    chk("mrst_b1_res", result, 64'h3);
    // reserved SEW from IDLE
    beat(2'b11, p, 4'b0000, 4'b0000);
    chk("rsvd_err", 64'(err), 64'h1);
    chk("rsvd_ov", 64'(out_valid), 64'h0);
    chk("rsvd_hold", result, 64'h3);
    idle();
    chk("rsvd_pulse", 64'(err), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
